// File: rtl/rd_lat_probe.sv
// Read-latency probe: samples one outstanding MRd tag at a time, emits a busy
// level / stop pulse pair for the max-latency stage and keeps CSR counters.
module rd_lat_probe #(
   parameter int TAG_W       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [7:0]       sample_div,
   input  logic             req_valid,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             cpl_valid,
   input  logic [TAG_W-1:0] cpl_tag,
   input  logic             cpl_last,
   input  logic             cpl_err,
   input  logic             clear,
   output logic             meas_busy,
   output logic             meas_stop,
   output logic [TAG_W-1:0] meas_tag,
   output logic [31:0]      sample_cnt,
   output logic [15:0]      timeout_cnt,
   output logic [15:0]      err_cnt
);

   localparam int TMR_W = 20;
   localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, TRACK, STOP} state_t;

   state_t           state;
   logic [7:0]       div_cnt;
   logic [TMR_W-1:0] timer;
   logic             hit, end_ok, end_to;

   // A match wins over a timeout landing in the same cycle.
   always_comb begin
      hit    = cpl_valid && (cpl_tag == meas_tag) && (cpl_last || cpl_err);
      end_ok = (state == TRACK) && hit;
      end_to = (state == TRACK) && !hit && (timer == TMO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         meas_busy   <= 1'b0;
         meas_stop   <= 1'b0;
         meas_tag    <= '0;
         div_cnt     <= '0;
         timer       <= '0;
         sample_cnt  <= '0;
         timeout_cnt <= '0;
         err_cnt     <= '0;
      end else begin
         meas_stop <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && req_valid) begin
                  if (div_cnt == 8'd0) begin
                     meas_tag  <= req_tag;
                     timer     <= TMR_W'(1);
                     div_cnt   <= sample_div;
                     state     <= TRACK;
                     meas_busy <= 1'b1;
                  end else begin
                     div_cnt <= div_cnt - 8'd1;
                  end
               end
            end
            TRACK: begin
               if (end_ok || end_to) begin
                  state     <= STOP;
                  meas_busy <= 1'b0;
                  meas_stop <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            STOP:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // Statistics: clear dominates any increment in the same cycle.
         if (clear) begin
            sample_cnt  <= '0;
            timeout_cnt <= '0;
            err_cnt     <= '0;
         end else begin
            if (end_ok && sample_cnt != '1)           sample_cnt  <= sample_cnt + 32'd1;
            if (end_ok && cpl_err && err_cnt != '1)   err_cnt     <= err_cnt + 16'd1;
            if (end_to && timeout_cnt != '1)          timeout_cnt <= timeout_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rd_lat_probe.sv
// Bench for rd_lat_probe: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a cycle-count based model.
module tb_rd_lat_probe;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst, enable, req_valid, cpl_valid, cpl_last, cpl_err, clear;
   logic [7:0]  sample_div, req_tag, cpl_tag, meas_tag;
   logic        meas_busy, meas_stop;
   logic [31:0] sample_cnt;
   logic [15:0] timeout_cnt, err_cnt;

   rd_lat_probe #(.TAG_W(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_div(sample_div),
      .req_valid(req_valid), .req_tag(req_tag), .cpl_valid(cpl_valid),
      .cpl_tag(cpl_tag), .cpl_last(cpl_last), .cpl_err(cpl_err), .clear(clear),
      .meas_busy(meas_busy), .meas_stop(meas_stop), .meas_tag(meas_tag),
      .sample_cnt(sample_cnt), .timeout_cnt(timeout_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // Reference: one outstanding sample described by its capture cycle.
   bit          m_act, m_stop;
   logic [7:0]  m_tag;
   int          m_start, m_skip;
   logic [31:0] m_samp;
   logic [15:0] m_to, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, cyc_n, act, exp);
      end
   endtask

   task automatic model_step();
      bit nstop = 0;
      if (rst) begin
         m_act = 0; m_stop = 0; m_tag = 0; m_skip = 0;
         m_samp = 0; m_to = 0; m_err = 0;
         return;
      end
      if (m_act) begin
         if (cpl_valid && cpl_tag == m_tag && (cpl_last || cpl_err)) begin
            m_act = 0; nstop = 1;
            if (m_samp != 32'hFFFF_FFFF) m_samp++;
            if (cpl_err && m_err != 16'hFFFF) m_err++;
         end else if (cyc_n - m_start == TO) begin
            m_act = 0; nstop = 1;
            if (m_to != 16'hFFFF) m_to++;
         end
      end else if (!m_stop && enable && req_valid) begin
         if (m_skip == 0) begin
            m_act = 1; m_tag = req_tag; m_start = cyc_n; m_skip = sample_div;
         end else m_skip--;
      end
      if (clear) begin m_samp = 0; m_to = 0; m_err = 0; end
      m_stop = nstop;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      cyc_n++;
      chk("busy", meas_busy, m_act);
      chk("stop", meas_stop, m_stop);
      chk("tag", meas_tag, m_tag);
      chk("sample_cnt", sample_cnt, m_samp);
      chk("timeout_cnt", timeout_cnt, m_to);
      chk("err_cnt", err_cnt, m_err);
   endtask

   task automatic idle_in();
      req_valid = 0; cpl_valid = 0; cpl_last = 0; cpl_err = 0; clear = 0;
   endtask

   typedef struct {
      bit rv; logic [7:0] rt;
      bit cv; logic [7:0] ct; bit cl; bit ce;
      bit eb; bit es;
   } vec_t;

   vec_t vt[11];

   initial begin
      // Expected outputs are the values seen after that row's clock edge.
      vt[0]  = '{1, 8'h07, 0, 8'h00, 0, 0, 1, 0};   // capture 0x07
      vt[1]  = '{0, 8'h00, 1, 8'h08, 1, 0, 1, 0};   // other tag
      vt[2]  = '{0, 8'h00, 1, 8'h08, 1, 1, 1, 0};
      vt[3]  = '{0, 8'h00, 1, 8'h07, 0, 0, 1, 0};   // non-last, same tag
      vt[4]  = '{0, 8'h00, 0, 8'h00, 0, 0, 1, 0};
      vt[5]  = '{0, 8'h00, 1, 8'h07, 1, 0, 0, 1};   // last -> stop
      vt[6]  = '{1, 8'h09, 0, 8'h00, 0, 0, 0, 0};   // request in STOP ignored
      vt[7]  = '{1, 8'h0A, 0, 8'h00, 0, 0, 1, 0};   // captured one cycle later
      vt[8]  = '{0, 8'h00, 1, 8'h0A, 1, 1, 0, 1};   // error end
      vt[9]  = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0};
      vt[10] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0};

      rst = 1; enable = 1; sample_div = 0; req_tag = 0; cpl_tag = 0;
      idle_in();
      tick(); tick();
      chk("rst_busy", meas_busy, 0);
      chk("rst_stop", meas_stop, 0);
      chk("rst_tag", meas_tag, 0);
      chk("rst_samp", sample_cnt, 0);
      rst = 0;
      tick();

      for (int i = 0; i < 11; i++) begin
         req_valid = vt[i].rv; req_tag = vt[i].rt;
         cpl_valid = vt[i].cv; cpl_tag = vt[i].ct;
         cpl_last = vt[i].cl; cpl_err = vt[i].ce;
         tick();
         chk($sformatf("vec%0d_busy", i), meas_busy, vt[i].eb);
         chk($sformatf("vec%0d_stop", i), meas_stop, vt[i].es);
      end
      chk("vec_samp", sample_cnt, 2);
      chk("vec_err", err_cnt, 1);

      // Divider: 1 of every 3 requests captured.
      sample_div = 2;
      for (int i = 0; i < 6; i++) begin
         idle_in(); req_valid = 1; req_tag = 8'h10 + 8'(i);
         tick();
         chk($sformatf("div_cap%0d", i), meas_busy, (i % 3 == 0));
         idle_in(); cpl_valid = 1; cpl_last = 1; cpl_tag = 8'h10 + 8'(i);
         tick();
         idle_in(); tick();
      end
      chk("div_samp", sample_cnt, 4);
      sample_div = 0;

      // Timeout with no completion: stop at T+65.
      idle_in(); req_valid = 1; req_tag = 8'h20; tick();
      idle_in();
      for (int k = 0; k < 63; k++) tick();
      chk("to_busy_last", meas_busy, 1);
      tick();
      chk("to_stop", meas_stop, 1);
      chk("to_cnt", timeout_cnt, 1);
      tick();

      // Completion exactly at T+64 counts as a normal end.
      req_valid = 1; req_tag = 8'h21; tick();
      idle_in();
      for (int k = 0; k < 63; k++) tick();
      cpl_valid = 1; cpl_last = 1; cpl_tag = 8'h21; tick();
      chk("edge_stop", meas_stop, 1);
      chk("edge_samp", sample_cnt, 5);
      chk("edge_to", timeout_cnt, 1);
      idle_in(); tick();

      // Clear coincident with an ending event.
      req_valid = 1; req_tag = 8'h30; tick();
      idle_in(); tick();
      cpl_valid = 1; cpl_last = 1; cpl_tag = 8'h30; clear = 1; tick();
      chk("clr_stop", meas_stop, 1);
      chk("clr_samp", sample_cnt, 0);
      chk("clr_to", timeout_cnt, 0);
      idle_in(); tick();

      // Reset in the middle of a measurement.
      req_valid = 1; req_tag = 8'h31; tick();
      idle_in(); tick(); tick();
      rst = 1; tick();
      chk("mid_rst_busy", meas_busy, 0);
      chk("mid_rst_stop", meas_stop, 0);
      rst = 0; tick();
      chk("post_rst_stop", meas_stop, 0);

      // Random traffic on a small tag space so matches are frequent.
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 499) == 0);
         enable     = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) sample_div = 8'($urandom_range(0, 2));
         req_valid  = ($urandom_range(0, 9) < 3);
         req_tag    = 8'($urandom_range(0, 3));
         cpl_valid  = ($urandom_range(0, 9) < 3);
         cpl_tag    = 8'($urandom_range(0, 3));
         cpl_last   = $urandom_range(0, 1);
         cpl_err    = ($urandom_range(0, 9) == 0);
         clear      = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rd_lat_probe.md
# rd_lat_probe

Upstream measurement front-end for the PCIe read-latency max tracker. Watches non-posted memory-read requests leaving the TX path and completions arriving on RX. Samples one outstanding read tag at a time. Converts each sample into the level/pulse pair the max-count stage consumes: `meas_busy` drives its start input and `meas_stop` drives its stop input. Also keeps saturating sample, timeout and error counters for CSR readout.

## Interface
- `TAG_W`, default 8: PCIe tag width.
- `TIMEOUT_CYC`, default 50000: abort threshold in cycles; must be ≥ 2 and < 2^20.
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: allows new captures.
- `sample_div` in 8: capture 1 of every `sample_div`+1 eligible requests.
- `req_valid` in 1: MRd header accepted by TX this cycle.
- `req_tag` in `TAG_W`: tag of that MRd.
- `cpl_valid` in 1: completion header observed on RX this cycle.
- `cpl_tag` in `TAG_W`: completion tag.
- `cpl_last` in 1: this completion finishes its request.
- `cpl_err` in 1: completion status is not SC.
- `clear` in 1: zeroes the statistics counters.
- `meas_busy` out 1: level; high while the sampled read is outstanding.
- `meas_stop` out 1: one-cycle pulse ending a measurement.
- `meas_tag` out `TAG_W`: tag currently or last tracked.
- `sample_cnt` out 32: normal (non-timeout) measurements completed, saturating.
- `timeout_cnt` out 16: timeouts, saturating.
- `err_cnt` out 16: measurements ended by an error completion, saturating.

## Operation
- FSM states: IDLE, TRACK, STOP. Reset state is IDLE.
- Outputs are registered: `meas_busy` = (state==TRACK); `meas_stop` = (state==STOP).
- IDLE, while `enable` and `req_valid` are both high:
  - `div_cnt`==0: capture `req_tag` into `meas_tag`, set `timer`<=1, set `div_cnt`<=`sample_div`, go to TRACK.
  - `div_cnt`!=0: decrement `div_cnt`; no capture.
  - `div_cnt` resets to 0, so the first request after reset is captured.
- TRACK ends on the first of two events; both go to STOP:
  - Match: `cpl_valid` && `cpl_tag`==`meas_tag` && (`cpl_last` || `cpl_err`).
  - Timeout: no match this cycle && `timer`==`TIMEOUT_CYC`.
- Otherwise in TRACK, `timer` increments by 1 each cycle.
- A match in the same cycle `timer` reaches `TIMEOUT_CYC` is a normal end, not a timeout.
- STOP lasts exactly one cycle, then returns to IDLE.
- Requests presented in TRACK or STOP are ignored and do not decrement `div_cnt`. This guarantees `meas_busy` never overlaps `meas_stop`.
- Completions that are ignored: a different tag, or `cpl_last`=0 with `cpl_err`=0. A late completion of a timed-out tag is also ignored unless that tag has been re-captured.
- Deasserting `enable` during TRACK does not abort; the measurement finishes normally.
- Counter updates are applied on the TRACK→STOP transition:
  - Normal match: `sample_cnt`+1.
  - Match with `cpl_err`=1: `err_cnt`+1 in addition.
  - Timeout: `timeout_cnt`+1 only.
- All counters saturate at all-ones.
- `clear` zeroes all three counters; it wins over a same-cycle increment. `clear` does not affect the FSM, `div_cnt` or `meas_tag`.

## Timing
- Request captured at cycle T; ending condition detected at cycle X:
  - `meas_busy` is high for cycles T+1..X.
  - `meas_stop` is high at X+1.
  - The downstream max stage therefore records X−T.
- Timeout occurs at X = T+`TIMEOUT_CYC`, so the recorded value is exactly `TIMEOUT_CYC`.
- Earliest next capture is cycle X+2; the earliest next `meas_busy` is X+3.
- Reset values: `meas_busy`=0, `meas_stop`=0, `meas_tag`=0, all counters 0, `div_cnt`=0, `timer`=0.
- Reset asserted mid-TRACK: `meas_busy` is 0 the cycle after `rst` is sampled high, and no `meas_stop` is generated. The downstream stage is reset from the same source.
- Counter outputs update one cycle after the ending event, i.e. coincident with `meas_stop`.

## Test plan
- Basic latency: `sample_div`=0. Request tag 0x05 at cycle 10; last completion tag 0x05 at cycle 20. Expect `meas_busy` high for cycles 11–20, `meas_stop` at 21, `sample_cnt`=1.
- Sampling divider: `sample_div`=2; send 6 spaced requests, each completed. Expect captures of requests 1 and 4 only, `sample_cnt`=2.
- Ignored completions: while tracking tag 0x07, send completions for tag 0x08 and a non-last completion for 0x07. Expect `meas_busy` to stay high; the stop pulse follows only the last completion for 0x07.
- Timeout: `TIMEOUT_CYC`=64, no completion. Expect `meas_stop` at T+65 and `timeout_cnt`=1. A completion at exactly T+64 instead counts as normal (`sample_cnt`+1).
- Error and back-to-back: end with `cpl_err`=1 → `err_cnt`=1 and `sample_cnt`=1. A request in the STOP cycle is not captured; a request one cycle later is captured.
- Clear/reset: `clear` in the same cycle as an ending event → counters read 0. `rst` mid-TRACK → `meas_busy`=0 next cycle, no `meas_stop`.
